cut_step_driver: RTL and testbench

//  Cut-motor driver: receives en/direction from the cut controller and turns them into a
//  4-phase full-step stepper sequence at a fixed step rate.

---
 rtl/cut_step_driver_if.sv | 30 +++
 rtl/cut_step_driver.sv | 136 +++++++++++++
 tb/tb_cut_step_driver.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/cut_step_driver_if.sv
// Cut-motor driver interface: groups the controller-facing command inputs and the
// coil / status outputs of cut_step_driver.
//   en_i, direction_i   : command from the cut controller
//   phase_o             : coil drive {D,C,B,A}
//   step_pulse_o        : 1-cycle pulse per phase change
//   stroke_done_o       : 1-cycle pulse when a full stroke completes
//   busy_o              : high while running
//   pos_o               : two's-complement blade position
// Modports: master = cut controller side, slave = driver side.
interface cut_step_driver_if #(
    parameter int unsigned POS_W = 16
);
    logic             en_i;
    logic             direction_i;
    logic [3:0]       phase_o;
    logic             step_pulse_o;
    logic             stroke_done_o;
    logic             busy_o;
    logic [POS_W-1:0] pos_o;

    modport master (
        output en_i, direction_i,
        input  phase_o, step_pulse_o, stroke_done_o, busy_o, pos_o
    );

    modport slave (
        input  en_i, direction_i,
        output phase_o, step_pulse_o, stroke_done_o, busy_o, pos_o
    );
endinterface

// File: rtl/cut_step_driver.sv
// Cut-motor stepper driver. Turns en/direction from the cut controller into a 4-phase
// full-step coil sequence at one step every STEP_DIV clocks, tracks a signed position
// and pulses stroke_done_o after STEPS_PER_STROKE steps in one direction.
// Ports:
//   clk     : system clock
//   rst     : asynchronous active-high reset
//   io_bus  : cut_step_driver_if.slave (en_i, direction_i in; phase_o, step_pulse_o,
//             stroke_done_o, busy_o, pos_o out; all outputs registered)
module cut_step_driver #(
    parameter int unsigned STEP_DIV         = 250000,
    parameter int unsigned STEPS_PER_STROKE = 512,
    parameter int unsigned POS_W            = 16
) (
    input  logic               clk,
    input  logic               rst,
    cut_step_driver_if.slave   io_bus
);
    localparam int unsigned PRESC_W = $clog2(STEP_DIV);
    localparam int unsigned CNT_W   = $clog2(STEPS_PER_STROKE + 1);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(STEP_DIV - 1);
    localparam logic [CNT_W-1:0]   CNT_STROKE = CNT_W'(STEPS_PER_STROKE);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    function automatic logic [3:0] phase_lut(input logic [1:0] idx);
        logic [3:0] pat;
        case (idx)
            2'd0:    pat = 4'b0011;
            2'd1:    pat = 4'b0110;
            2'd2:    pat = 4'b1100;
            default: pat = 4'b1001;
        endcase
        return pat;
    endfunction

    state_e             r_state,       w_state_nxt;
    logic [1:0]         r_phase_idx,   w_phase_idx_nxt;
    logic               r_dir,         w_dir_nxt;
    logic [PRESC_W-1:0] r_presc,       w_presc_nxt;
    logic [CNT_W-1:0]   r_step_cnt,    w_step_cnt_nxt;
    logic [3:0]         r_phase,       w_phase_nxt;
    logic               r_step_pulse,  w_step_pulse_nxt;
    logic               r_stroke_done, w_stroke_done_nxt;
    logic               r_busy,        w_busy_nxt;
    logic [POS_W-1:0]   r_pos,         w_pos_nxt;
    logic [CNT_W-1:0]   w_cnt_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= StIdle;
            r_phase_idx   <= 2'd0;
            r_dir         <= 1'b0;
            r_presc       <= '0;
            r_step_cnt    <= '0;
            r_phase       <= 4'b0000;
            r_step_pulse  <= 1'b0;
            r_stroke_done <= 1'b0;
            r_busy        <= 1'b0;
            r_pos         <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_phase_idx   <= w_phase_idx_nxt;
            r_dir         <= w_dir_nxt;
            r_presc       <= w_presc_nxt;
            r_step_cnt    <= w_step_cnt_nxt;
            r_phase       <= w_phase_nxt;
            r_step_pulse  <= w_step_pulse_nxt;
            r_stroke_done <= w_stroke_done_nxt;
            r_busy        <= w_busy_nxt;
            r_pos         <= w_pos_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_phase_idx_nxt   = r_phase_idx;
        w_dir_nxt         = r_dir;
        w_presc_nxt       = r_presc;
        w_step_cnt_nxt    = r_step_cnt;
        w_phase_nxt       = r_phase;
        w_step_pulse_nxt  = 1'b0;
        w_stroke_done_nxt = 1'b0;
        w_busy_nxt        = r_busy;
        w_pos_nxt         = r_pos;
        w_cnt_inc         = r_step_cnt + 1'b1;

        case (r_state)
            StIdle: begin
                if (io_bus.en_i) begin
                    // Re-energise at the retained index so the rotor does not jump.
                    w_state_nxt    = StRun;
                    w_phase_nxt    = phase_lut(r_phase_idx);
                    w_busy_nxt     = 1'b1;
                    w_presc_nxt    = '0;
                    w_step_cnt_nxt = '0;
                    w_dir_nxt      = io_bus.direction_i;
                end
            end
            StRun: begin
                if (!io_bus.en_i) begin
                    w_state_nxt    = StIdle;
                    w_phase_nxt    = 4'b0000;
                    w_busy_nxt     = 1'b0;
                    w_presc_nxt    = '0;
                    w_step_cnt_nxt = '0;
                end else if (io_bus.direction_i != r_dir) begin
                    // Direction reversal: restart the step interval as a settle time.
                    w_dir_nxt      = io_bus.direction_i;
                    w_presc_nxt    = '0;
                    w_step_cnt_nxt = '0;
                end else if (r_presc == PRESC_LAST) begin
                    w_presc_nxt      = '0;
                    w_phase_idx_nxt  = r_dir ? r_phase_idx - 2'd1 : r_phase_idx + 2'd1;
                    w_phase_nxt      = phase_lut(w_phase_idx_nxt);
                    w_step_pulse_nxt = 1'b1;
                    w_pos_nxt        = r_dir ? r_pos - 1'b1 : r_pos + 1'b1;
                    if (w_cnt_inc == CNT_STROKE) begin
                        w_step_cnt_nxt    = '0;
                        w_stroke_done_nxt = 1'b1;
                    end else begin
                        w_step_cnt_nxt = w_cnt_inc;
                    end
                end else begin
                    w_presc_nxt = r_presc + 1'b1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    assign io_bus.phase_o       = r_phase;
    assign io_bus.step_pulse_o  = r_step_pulse;
    assign io_bus.stroke_done_o = r_stroke_done;
    assign io_bus.busy_o        = r_busy;
    assign io_bus.pos_o         = r_pos;
endmodule

// File: tb/tb_cut_step_driver.sv
// Directed bench for cut_step_driver with STEP_DIV=4, STEPS_PER_STROKE=3.
// Instance A (POS_W=16) covers the main sequence; instance B (POS_W=4) covers position wrap.
module tb_cut_step_driver;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cut_step_driver_if #(.POS_W(16)) bus_a ();
    cut_step_driver_if #(.POS_W(4))  bus_b ();

    cut_step_driver #(.STEP_DIV(4), .STEPS_PER_STROKE(3), .POS_W(16)) u_dut_a (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus_a.slave)
    );

    cut_step_driver #(.STEP_DIV(4), .STEPS_PER_STROKE(3), .POS_W(4)) u_dut_b (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus_b.slave)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned pa_cnt, sa_cnt, pb_cnt, sb_cnt;
    int unsigned bad_pulse = 0;
    logic prev_pa = 1'b0;
    logic prev_pb = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_counts();
        pa_cnt = 0;
        sa_cnt = 0;
        pb_cnt = 0;
        sb_cnt = 0;
    endtask

    // Advance n edges, sampling 1 time unit after each; pulse-shape violations are tallied.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (bus_a.step_pulse_o) pa_cnt++;
            if (bus_a.stroke_done_o) sa_cnt++;
            if (bus_a.step_pulse_o && prev_pa) bad_pulse++;
            if (bus_a.stroke_done_o && !bus_a.step_pulse_o) bad_pulse++;
            prev_pa = bus_a.step_pulse_o;
            if (bus_b.step_pulse_o) pb_cnt++;
            if (bus_b.stroke_done_o) sb_cnt++;
            if (bus_b.step_pulse_o && prev_pb) bad_pulse++;
            if (bus_b.stroke_done_o && !bus_b.step_pulse_o) bad_pulse++;
            prev_pb = bus_b.step_pulse_o;
        end
    endtask

    initial begin
        rst               = 1'b1;
        bus_a.en_i        = 1'b0;
        bus_a.direction_i = 1'b0;
        bus_b.en_i        = 1'b0;
        bus_b.direction_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset
        clr_counts();
        tick(10);
        check_eq("idle_phase", 32'(bus_a.phase_o), 32'h0);
        check_eq("idle_pos", 32'(bus_a.pos_o), 32'h0);
        check_eq("idle_busy", 32'(bus_a.busy_o), 32'h0);
        check_eq("idle_pulses", pa_cnt + sa_cnt, 32'h0);

        // Clockwise stroke
        bus_a.en_i = 1'b1;
        bus_a.direction_i = 1'b0;
        clr_counts();
        tick(1);
        check_eq("entry_phase", 32'(bus_a.phase_o), 32'b0011);
        check_eq("entry_busy", 32'(bus_a.busy_o), 32'h1);
        tick(3);
        check_eq("no_early_step", pa_cnt, 32'h0);
        tick(1);
        check_eq("cw1_phase", 32'(bus_a.phase_o), 32'b0110);
        check_eq("cw1_pulse", 32'(bus_a.step_pulse_o), 32'h1);
        check_eq("cw1_pos", 32'(bus_a.pos_o), 32'h1);
        tick(4);
        check_eq("cw2_phase", 32'(bus_a.phase_o), 32'b1100);
        check_eq("cw2_pos", 32'(bus_a.pos_o), 32'h2);
        check_eq("cw2_no_stroke", sa_cnt, 32'h0);
        tick(4);
        check_eq("cw3_phase", 32'(bus_a.phase_o), 32'b1001);
        check_eq("cw3_pos", 32'(bus_a.pos_o), 32'h3);
        check_eq("cw3_stroke", 32'(bus_a.stroke_done_o), 32'h1);
        check_eq("cw_step_count", pa_cnt, 32'h3);
        check_eq("cw_stroke_count", sa_cnt, 32'h1);
        tick(1);
        check_eq("stroke_one_cycle", 32'(bus_a.stroke_done_o), 32'h0);

        // Reverse to counterclockwise: settle interval, then 3->2->1->0->3
        bus_a.direction_i = 1'b1;
        clr_counts();
        tick(4);
        check_eq("settle_no_step", pa_cnt, 32'h0);
        check_eq("settle_phase", 32'(bus_a.phase_o), 32'b1001);
        tick(1);
        check_eq("ccw1_phase", 32'(bus_a.phase_o), 32'b1100);
        check_eq("ccw1_pos", 32'(bus_a.pos_o), 32'h2);
        tick(4);
        check_eq("ccw2_phase", 32'(bus_a.phase_o), 32'b0110);
        check_eq("ccw2_pos", 32'(bus_a.pos_o), 32'h1);
        tick(4);
        check_eq("ccw3_phase", 32'(bus_a.phase_o), 32'b0011);
        check_eq("ccw3_pos", 32'(bus_a.pos_o), 32'h0);
        check_eq("ccw3_stroke", 32'(bus_a.stroke_done_o), 32'h1);
        tick(4);
        check_eq("ccw4_wrap_phase", 32'(bus_a.phase_o), 32'b1001);
        check_eq("ccw4_pos_neg", 32'(bus_a.pos_o), 32'hFFFF);
        check_eq("ccw_stroke_count", sa_cnt, 32'h1);

        // Disable on the edge where presc==3
        tick(3);
        bus_a.en_i = 1'b0;
        clr_counts();
        tick(1);
        check_eq("dis_no_step", pa_cnt, 32'h0);
        check_eq("dis_phase", 32'(bus_a.phase_o), 32'h0);
        check_eq("dis_busy", 32'(bus_a.busy_o), 32'h0);
        check_eq("dis_pos_kept", 32'(bus_a.pos_o), 32'hFFFF);

        // Re-enable: last pattern restored, stroke counter restarted
        bus_a.en_i = 1'b1;
        tick(1);
        check_eq("reen_phase", 32'(bus_a.phase_o), 32'b1001);
        check_eq("reen_busy", 32'(bus_a.busy_o), 32'h1);
        clr_counts();
        tick(8);
        check_eq("reen_two_steps", pa_cnt, 32'h2);
        check_eq("reen_no_early_stroke", sa_cnt, 32'h0);
        check_eq("reen_pos", 32'(bus_a.pos_o), 32'hFFFD);
        tick(4);
        check_eq("reen_stroke3", 32'(bus_a.stroke_done_o), 32'h1);
        check_eq("reen_phase3", 32'(bus_a.phase_o), 32'b0011);
        check_eq("reen_pos3", 32'(bus_a.pos_o), 32'hFFFC);

        // Asynchronous reset at presc=2, checked before the next edge
        tick(2);
        #3;
        rst = 1'b1;
        bus_a.en_i = 1'b0;
        #1;
        check_eq("arst_phase", 32'(bus_a.phase_o), 32'h0);
        check_eq("arst_busy", 32'(bus_a.busy_o), 32'h0);
        check_eq("arst_pos", 32'(bus_a.pos_o), 32'h0);
        check_eq("arst_pulse", 32'(bus_a.step_pulse_o), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        prev_pa = 1'b0;
        prev_pb = 1'b0;

        // POS_W=4 wrap: 9 cw steps from 0 -> 4'b1001
        bus_b.en_i = 1'b1;
        bus_b.direction_i = 1'b0;
        clr_counts();
        tick(1);
        check_eq("b_entry_phase", 32'(bus_b.phase_o), 32'b0011);
        tick(32);
        check_eq("b_pos8", 32'(bus_b.pos_o), 32'h8);
        check_eq("b_phase8", 32'(bus_b.phase_o), 32'b0011);
        tick(4);
        check_eq("b_pos9_wrap", 32'(bus_b.pos_o), 32'h9);
        check_eq("b_phase9", 32'(bus_b.phase_o), 32'b0110);
        check_eq("b_busy", 32'(bus_b.busy_o), 32'h1);
        check_eq("b_steps", pb_cnt, 32'd9);
        check_eq("b_strokes", sb_cnt, 32'd3);
        check_eq("a_stays_idle", 32'(bus_a.phase_o), 32'h0);

        check_eq("pulse_shape", bad_pulse, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
